// File: rtl/mc_control_fsm_if.sv
// ============================================================================
// Module   : mc_control_fsm_if
// Brief    : Instruction/flag inputs and datapath control strobes between the
//            multicycle control unit (master) and the ARM datapath (slave).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mc_control_fsm_if;
   logic [31:12] Instr;
   logic [3:0]   ALUFlags;
   logic         PCWrite;
   logic         MemWrite;
   logic         RegWrite;
   logic         IRWrite;
   logic         AdrSrc;
   logic [1:0]   RegSrc;
   logic [1:0]   ALUSrcA;
   logic [1:0]   ALUSrcB;
   logic [1:0]   ResultSrc;
   logic [1:0]   ImmSrc;
   logic [1:0]   ALUControl;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
   );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module   : mc_control_fsm
// Brief    : ARM multicycle control unit: Moore state machine, NZCV flag
//            register and condition check driving every datapath strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_control_fsm (
   input  wire logic        clk,
   input  wire logic        reset,
   mc_control_fsm_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECR   = 4'd6,
      S_EXECI   = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9
   } state_t;

   localparam logic [3:0] c_cmd_and = 4'b0000;
   localparam logic [3:0] c_cmd_sub = 4'b0010;
   localparam logic [3:0] c_cmd_add = 4'b0100;
   localparam logic [3:0] c_cmd_cmp = 4'b1010;
   localparam logic [3:0] c_cmd_orr = 4'b1100;

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_flags;
   logic       r_condq;

   logic [3:0] w_cond;
   logic [1:0] w_op;
   logic [5:0] w_funct;
   logic [3:0] w_cmd;
   logic       w_rd_pc;
   logic       w_unused_rn;

   assign w_cond      = bus.Instr[31:28];
   assign w_op        = bus.Instr[27:26];
   assign w_funct     = bus.Instr[25:20];
   assign w_cmd       = w_funct[4:1];
   assign w_rd_pc     = (bus.Instr[15:12] == 4'hF);
   assign w_unused_rn = &{1'b0, bus.Instr[19:16]};

   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = r_flags;

   logic w_condex;
   always_comb begin
      w_condex = 1'b0;
      case (w_cond)
         4'b0000: w_condex = w_z;
         4'b0001: w_condex = ~w_z;
         4'b0010: w_condex = w_c;
         4'b0011: w_condex = ~w_c;
         4'b0100: w_condex = w_n;
         4'b0101: w_condex = ~w_n;
         4'b0110: w_condex = w_v;
         4'b0111: w_condex = ~w_v;
         4'b1000: w_condex = w_c & ~w_z;
         4'b1001: w_condex = ~w_c | w_z;
         4'b1010: w_condex = ~(w_n ^ w_v);
         4'b1011: w_condex = w_n ^ w_v;
         4'b1100: w_condex = ~w_z & ~(w_n ^ w_v);
         4'b1101: w_condex = w_z | (w_n ^ w_v);
         4'b1110: w_condex = 1'b1;
         default: w_condex = 1'b0;
      endcase
   end

   // Unsupported commands behave like a write-suppressed add with no flag effect.
   logic [1:0] w_aluctl;
   logic       w_cmd_arith;
   logic       w_cmd_valid;
   logic       w_nowrite;
   always_comb begin
      w_aluctl    = 2'b00;
      w_cmd_arith = 1'b0;
      w_cmd_valid = 1'b1;
      w_nowrite   = 1'b0;
      case (w_cmd)
         c_cmd_add: w_cmd_arith = 1'b1;
         c_cmd_sub: begin
            w_aluctl    = 2'b01;
            w_cmd_arith = 1'b1;
         end
         c_cmd_and: w_aluctl = 2'b10;
         c_cmd_orr: w_aluctl = 2'b11;
         c_cmd_cmp: begin
            w_aluctl    = 2'b01;
            w_cmd_arith = 1'b1;
            w_nowrite   = 1'b1;
         end
         default: begin
            w_cmd_valid = 1'b0;
            w_nowrite   = 1'b1;
         end
      endcase
   end

   logic w_in_exec;
   logic w_setflags;
   assign w_in_exec  = (r_state == S_EXECR) || (r_state == S_EXECI);
   assign w_setflags = w_in_exec & r_condq & w_funct[0] & w_cmd_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_flags <= 4'b0000;
         r_condq <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_condq <= w_condex;
         end
         if (w_setflags) begin
            r_flags[3:2] <= bus.ALUFlags[3:2];
            if (w_cmd_arith) begin
               r_flags[1:0] <= bus.ALUFlags[1:0];
            end
         end
      end
   end

   logic       w_pcwrite;
   logic       w_memwrite;
   logic       w_regwrite;
   logic       w_irwrite;
   logic       w_adrsrc;
   logic [1:0] w_regsrc;
   logic [1:0] w_alusrca;
   logic [1:0] w_alusrcb;
   logic [1:0] w_resultsrc;
   logic [1:0] w_alucontrol;

   always_comb begin
      w_next       = S_FETCH;
      w_pcwrite    = 1'b0;
      w_memwrite   = 1'b0;
      w_regwrite   = 1'b0;
      w_irwrite    = 1'b0;
      w_adrsrc     = 1'b0;
      w_regsrc     = 2'b00;
      w_alusrca    = 2'b00;
      w_alusrcb    = 2'b00;
      w_resultsrc  = 2'b00;
      w_alucontrol = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_irwrite   = 1'b1;
            w_pcwrite   = 1'b1;
            w_alusrca   = 2'b01;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            w_next      = S_DECODE;
         end
         S_DECODE: begin
            w_alusrca   = 2'b01;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            case (w_op)
               2'b01:   w_next = S_MEMADR;
               2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
               2'b10:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            w_alusrcb = 2'b01;
            w_regsrc  = w_funct[0] ? 2'b00 : 2'b10;
            w_next    = w_funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_adrsrc = 1'b1;
            w_next   = S_MEMWB;
         end
         S_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regwrite  = r_condq;
            w_pcwrite   = r_condq & w_rd_pc;
            w_next      = S_FETCH;
         end
         S_MEMWR: begin
            w_adrsrc   = 1'b1;
            w_regsrc   = 2'b10;
            w_memwrite = r_condq;
            w_next     = S_FETCH;
         end
         S_EXECR: begin
            w_alucontrol = w_aluctl;
            w_next       = S_ALUWB;
         end
         S_EXECI: begin
            w_alusrcb    = 2'b01;
            w_alucontrol = w_aluctl;
            w_next       = S_ALUWB;
         end
         S_ALUWB: begin
            w_regwrite = r_condq & ~w_nowrite;
            w_pcwrite  = r_condq & ~w_nowrite & w_rd_pc;
            w_next     = S_FETCH;
         end
         S_BRANCH: begin
            w_regsrc    = 2'b01;
            w_alusrcb   = 2'b01;
            w_resultsrc = 2'b10;
            w_pcwrite   = r_condq;
            w_next      = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   assign bus.PCWrite    = w_pcwrite;
   assign bus.MemWrite   = w_memwrite;
   assign bus.RegWrite   = w_regwrite;
   assign bus.IRWrite    = w_irwrite;
   assign bus.AdrSrc     = w_adrsrc;
   assign bus.RegSrc     = w_regsrc;
   assign bus.ALUSrcA    = w_alusrca;
   assign bus.ALUSrcB    = w_alusrcb;
   assign bus.ResultSrc  = w_resultsrc;
   assign bus.ImmSrc     = w_op;
   assign bus.ALUControl = w_alucontrol;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Directed instruction sequences for mc_control_fsm; expected strobe
//            vectors are queued per cycle and checked by an independent monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

   logic clk;
   logic reset;

   mc_control_fsm_if bus();

   mc_control_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] v;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Packed order: PCWrite MemWrite RegWrite IRWrite AdrSrc RegSrc ALUSrcA
   //               ALUSrcB ResultSrc ALUControl (ImmSrc inserted at push time)
   function automatic logic [14:0] v(input logic pw, input logic mw, input logic rw,
                                     input logic iw, input logic ad, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] re, input logic [1:0] ac);
      return {pw, mw, rw, iw, ad, rs, sa, sb, re, ac};
   endfunction

   function automatic logic [14:0] e_fetch();
      return v(1, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00);
   endfunction
   function automatic logic [14:0] e_decode();
      return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00);
   endfunction

   task automatic step(input logic [31:0] ins, input logic [3:0] af,
                       input logic [14:0] e, input string tag);
      exp_t x;
      logic [1:0] imm;
      @(posedge clk);
      #1;
      reset        = 1'b0;
      bus.Instr    = ins[31:12];
      bus.ALUFlags = af;
      imm          = ins[27:26];
      x.v          = {e[14:2], imm, e[1:0]};
      x.tag        = tag;
      q.push_back(x);
   endtask

   task automatic dp_i(input logic [31:0] ins, input logic [3:0] af, input logic [1:0] ac,
                       input logic rw, input logic pw, input string tag);
      step(ins, af, e_fetch(),  {tag, ".fetch"});
      step(ins, af, e_decode(), {tag, ".decode"});
      step(ins, af, v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, ac), {tag, ".execi"});
      step(ins, af, v(pw, 0, rw, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), {tag, ".aluwb"});
   endtask

   task automatic dp_r(input logic [31:0] ins, input logic [3:0] af, input logic [1:0] ac,
                       input logic rw, input logic pw, input string tag);
      step(ins, af, e_fetch(),  {tag, ".fetch"});
      step(ins, af, e_decode(), {tag, ".decode"});
      step(ins, af, v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, ac), {tag, ".execr"});
      step(ins, af, v(pw, 0, rw, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), {tag, ".aluwb"});
   endtask

   task automatic br(input logic [31:0] ins, input logic pw, input string tag);
      step(ins, 4'b0000, e_fetch(),  {tag, ".fetch"});
      step(ins, 4'b0000, e_decode(), {tag, ".decode"});
      step(ins, 4'b0000, v(pw, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00), {tag, ".branch"});
   endtask

   task automatic ldr_head(input logic [31:0] ins, input string tag);
      step(ins, 4'b0000, e_fetch(),  {tag, ".fetch"});
      step(ins, 4'b0000, e_decode(), {tag, ".decode"});
      step(ins, 4'b0000, v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00), {tag, ".memadr"});
      step(ins, 4'b0000, v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00), {tag, ".memrd"});
   endtask

   task automatic ldr(input logic [31:0] ins, input logic rw, input logic pw, input string tag);
      ldr_head(ins, tag);
      step(ins, 4'b0000, v(pw, 0, rw, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00), {tag, ".memwb"});
   endtask

   task automatic str(input logic [31:0] ins, input logic mw, input string tag);
      step(ins, 4'b0000, e_fetch(),  {tag, ".fetch"});
      step(ins, 4'b0000, e_decode(), {tag, ".decode"});
      step(ins, 4'b0000, v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00), {tag, ".memadr"});
      step(ins, 4'b0000, v(0, mw, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00), {tag, ".memwr"});
   endtask

   // Monitor: the DUT presents a strobe vector every cycle; compare mid-cycle.
   initial begin
      exp_t        x;
      logic [16:0] act;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            x   = q.pop_front();
            act = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                   bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
                   bus.ALUControl};
            total++;
            if (act !== x.v) begin
               bad++;
               $display("FAIL %s: got %b want %b (pw mw rw iw ad rs sa sb re imm ac)",
                        x.tag, act, x.v);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.Instr    = '0;
      bus.ALUFlags = 4'b0000;
      repeat (3) @(posedge clk);

      // Flags clear after reset: ADD writes, BEQ not taken
      dp_i(32'hE2811005, 4'b0000, 2'b00, 1'b1, 1'b0, "add_imm");
      br  (32'h0A000002, 1'b0, "beq_z0");
      dp_i(32'hE3510000, 4'b0100, 2'b01, 1'b0, 1'b0, "cmp");
      br  (32'h0A000002, 1'b1, "beq_z1");
      br  (32'h1A000002, 1'b0, "bne_z1");
      ldr (32'hE5912004, 1'b1, 1'b0, "ldr");
      str (32'hE5812004, 1'b1, "str");
      str (32'h15812004, 1'b0, "strne_fail");
      dp_i(32'hE28FF008, 4'b0000, 2'b00, 1'b1, 1'b1, "add_pc");
      dp_i(32'hC2511001, 4'b1000, 2'b01, 1'b0, 1'b0, "subsgt_fail");
      br  (32'h0A000002, 1'b1, "beq_keep");
      br  (32'h4A000002, 1'b0, "bmi_keep");
      // ADDS sets C,V; ANDS then updates N,Z only
      dp_i(32'hE2911005, 4'b0011, 2'b00, 1'b1, 1'b0, "adds");
      br  (32'h2A000002, 1'b1, "bcs_c1");
      br  (32'h6A000002, 1'b1, "bvs_v1");
      br  (32'h0A000002, 1'b0, "beq_z0b");
      dp_i(32'hE2111000, 4'b1000, 2'b10, 1'b1, 1'b0, "ands");
      br  (32'h2A000002, 1'b1, "bcs_kept");
      br  (32'h4A000002, 1'b1, "bmi_n1");
      br  (32'hAA000002, 1'b1, "bge");
      br  (32'hBA000002, 1'b0, "blt");
      br  (32'h8A000002, 1'b1, "bhi");
      dp_r(32'hE1812003, 4'b0000, 2'b11, 1'b1, 1'b0, "orr_reg");
      dp_i(32'hF2811005, 4'b0000, 2'b00, 1'b0, 1'b0, "cond_nv");
      // Unsupported command: no write, no flag update even with S set
      dp_i(32'hE2311000, 4'b0100, 2'b00, 1'b0, 1'b0, "eors_unsup");
      br  (32'h0A000002, 1'b0, "beq_after_unsup");
      // Op=11 returns straight to FETCH after DECODE
      step(32'hEC000000, 4'b0000, e_fetch(),  "op11.fetch");
      step(32'hEC000000, 4'b0000, e_decode(), "op11.decode");
      br  (32'h4A000002, 1'b1, "bmi_after_op11");
      // Reset during MEMRD: back to FETCH, flags cleared, no write-back
      ldr_head(32'hE5912004, "ldr_rst");
      @(negedge clk);
      #1;
      reset = 1'b1;
      br  (32'h4A000002, 1'b0, "bmi_after_rst");
      br  (32'h5A000002, 1'b1, "bpl_after_rst");
      br  (32'h2A000002, 1'b0, "bcs_after_rst");
      br  (32'hEA000002, 1'b1, "bal");

      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
